// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and constants for the read-side FIFO packer.
// The default data width matches the async FIFO it drains.
package fifo_rd_packer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        FILL,
        HOLD
    } packerState_t;

    // Counter width able to hold the value PACK itself, not just PACK-1.
    function automatic int cntWidth(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops WIDTH-bit words from the async FIFO and emits PACK-lane words
// on a valid/ready port; a flush pulse pushes out a partial word with its lane count.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int PACK      = 4,
    parameter int OUT_WIDTH = WIDTH * PACK,
    parameter int CNT_WIDTH = cntWidth(PACK)
) (
    input  logic                 rd_clk,
    input  logic                 res,
    input  logic                 empty,
    input  logic [WIDTH-1:0]     rdata,
    output logic                 rd_en,
    input  logic                 flush,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam logic [CNT_WIDTH-1:0] PACK_CNT = CNT_WIDTH'(PACK);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    packerState_t         r_state;
    logic [CNT_WIDTH-1:0] r_issued;
    logic [CNT_WIDTH-1:0] r_filled;
    logic                 r_rdPending;
    logic                 r_flushReq;
    logic [WIDTH-1:0]     r_lanes [PACK];

    logic                 w_capture;
    logic [CNT_WIDTH-1:0] w_filledNext;
    logic                 w_fullCapture;
    logic                 w_flushDone;
    logic                 w_flushArm;
    logic                 w_handshake;
    logic [OUT_WIDTH-1:0] w_packed;

    assign rd_en = !res && (r_state == FILL) && !empty
                   && (r_issued < PACK_CNT) && !r_flushReq;

    assign w_capture     = r_rdPending && (r_state == FILL);
    assign w_filledNext  = w_capture ? (r_filled + CNT_ONE) : r_filled;
    assign w_fullCapture = w_capture && (w_filledNext == PACK_CNT);
    assign w_flushDone   = r_flushReq && !r_rdPending;
    assign w_flushArm    = flush && ((r_filled != '0) || r_rdPending);
    assign w_handshake   = out_valid && out_ready;

    // Lane view including this cycle's capture, so the word can register on the filling edge.
    always_comb begin
        w_packed = '0;
        for (int i = 0; i < PACK; i++) begin
            if (w_capture && (r_filled == CNT_WIDTH'(i))) begin
                w_packed[i*WIDTH +: WIDTH] = rdata;
            end else begin
                w_packed[i*WIDTH +: WIDTH] = r_lanes[i];
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (res) begin
            r_state     <= FILL;
            r_issued    <= '0;
            r_filled    <= '0;
            r_rdPending <= 1'b0;
            r_flushReq  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_count   <= '0;
            for (int i = 0; i < PACK; i++) begin
                r_lanes[i] <= '0;
            end
        end else begin
            r_rdPending <= rd_en;
            if (rd_en) begin
                r_issued <= r_issued + CNT_ONE;
            end

            case (r_state)
                FILL: begin
                    if (w_capture) begin
                        r_filled <= w_filledNext;
                        for (int i = 0; i < PACK; i++) begin
                            if (r_filled == CNT_WIDTH'(i)) begin
                                r_lanes[i] <= rdata;
                            end
                        end
                    end

                    // A capture that completes the word wins over a flush arriving with it.
                    if (w_fullCapture) begin
                        r_state    <= HOLD;
                        out_valid  <= 1'b1;
                        out_data   <= w_packed;
                        out_count  <= PACK_CNT;
                        r_flushReq <= 1'b0;
                    end else if (w_flushDone) begin
                        r_state   <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= w_packed;
                        out_count <= r_filled;
                    end else if (w_flushArm) begin
                        r_flushReq <= 1'b1;
                    end
                end

                HOLD: begin
                    if (w_handshake) begin
                        r_state    <= FILL;
                        out_valid  <= 1'b0;
                        out_data   <= '0;
                        out_count  <= '0;
                        r_filled   <= '0;
                        r_issued   <= '0;
                        r_flushReq <= 1'b0;
                        for (int i = 0; i < PACK; i++) begin
                            r_lanes[i] <= '0;
                        end
                    end
                end

                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-backed FIFO model, a table of directed packing vectors,
// hand-written corner sequences and a randomized run against a word-stream reference model.
module tb_fifo_rd_packer;

    localparam int WIDTH     = 8;
    localparam int PACK      = 4;
    localparam int OUT_WIDTH = WIDTH * PACK;
    localparam int CNT_WIDTH = $clog2(PACK + 1);

    logic                 rd_clk = 1'b0;
    logic                 res;
    logic                 empty;
    logic [WIDTH-1:0]     rdata = '0;
    logic                 rd_en;
    logic                 flush;
    logic                 out_ready;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] fifoMem [0:1023];
    int pushCnt      = 0;
    int popCnt       = 0;
    int underflowCnt = 0;

    typedef struct {
        logic [PACK-1:0][WIDTH-1:0] words;
        int                         nWords;
        bit                         doFlush;
        logic [OUT_WIDTH-1:0]       expData;
        int                         expCount;
    } vector_t;

    vector_t vecs [5];

    fifo_rd_packer #(
        .WIDTH (WIDTH),
        .PACK  (PACK)
    ) dut (
        .rd_clk    (rd_clk),
        .res       (res),
        .empty     (empty),
        .rdata     (rdata),
        .rd_en     (rd_en),
        .flush     (flush),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO read side: data appears the cycle after an accepted pop.
    assign empty = (pushCnt == popCnt);

    always @(posedge rd_clk) begin
        if (rd_en) begin
            if (empty) begin
                underflowCnt <= underflowCnt + 1;
            end else begin
                rdata  <= fifoMem[popCnt[9:0]];
                popCnt <= popCnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [OUT_WIDTH-1:0] actual,
                               input logic [OUT_WIDTH-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushWord(input logic [WIDTH-1:0] w);
        fifoMem[pushCnt[9:0]] = w;
        pushCnt++;
    endtask

    task automatic doReset();
        res       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge rd_clk);
        res = 1'b0;
    endtask

    task automatic waitValid(input string name, input int maxCycles);
        int n;
        n = 0;
        while (!out_valid && n < maxCycles) begin
            @(negedge rd_clk);
            n++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: out_valid got 0 expected 1", name);
        end
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
    endtask

    task automatic acceptWord(input string name);
        out_ready = 1'b1;
        @(negedge rd_clk);
        out_ready = 1'b0;
        checkOutput({name, "_valid_cleared"}, OUT_WIDTH'(out_valid), '0);
        checkOutput({name, "_data_cleared"}, out_data, '0);
    endtask

    task automatic applyStimulus(input vector_t v, input int idx);
        string name;
        name = $sformatf("vec%0d", idx);
        doReset();
        for (int k = 0; k < v.nWords; k++) begin
            pushWord(v.words[k]);
        end
        if (v.doFlush) begin
            repeat (8) @(negedge rd_clk);
            pulseFlush();
        end
        waitValid(name, 20);
        checkOutput({name, "_data"}, out_data, v.expData);
        checkOutput({name, "_count"}, OUT_WIDTH'(out_count), OUT_WIDTH'(v.expCount));
        acceptWord(name);
    endtask

    // Reference: words stream out in push order, PACK at a time; a flush after the FIFO
    // drains emits whatever is left over, low lane first, with zeros above.
    task automatic runRandom(input int nWords);
        logic [WIDTH-1:0]     refWords [$];
        logic [OUT_WIDTH-1:0] expData [$];
        int                   expCnt [$];
        logic [OUT_WIDTH-1:0] acc;
        logic [OUT_WIDTH-1:0] heldData;
        logic [WIDTH-1:0]     w;
        int pushed, cycles, got, expectedOuts, idle;
        bit holding, flushed;
        pushed = 0; cycles = 0; got = 0; idle = 0;
        holding = 1'b0; flushed = 1'b0; heldData = '0;
        expectedOuts = (nWords + PACK - 1) / PACK;
        doReset();
        while (got < expectedOuts && cycles < 4000) begin
            flush = 1'b0;
            if (holding) begin
                checkOutput("rand_hold_valid", OUT_WIDTH'(out_valid), OUT_WIDTH'(1));
                if (out_valid) checkOutput("rand_hold_stable", out_data, heldData);
            end
            if (out_valid) begin
                out_ready = ($urandom_range(0, 2) != 0);
                if (out_ready) begin
                    if (expData.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL rand_extra_word: got 0x%0h expected no word", out_data);
                    end else begin
                        checkOutput("rand_data", out_data, expData.pop_front());
                        checkOutput("rand_count", OUT_WIDTH'(out_count),
                                    OUT_WIDTH'(expCnt.pop_front()));
                    end
                    got++;
                    holding = 1'b0;
                end else begin
                    holding  = 1'b1;
                    heldData = out_data;
                end
            end else begin
                out_ready = ($urandom_range(0, 1) != 0);
                holding   = 1'b0;
            end

            if (pushed < nWords && $urandom_range(0, 1) == 1) begin
                w = WIDTH'($urandom);
                pushWord(w);
                refWords.push_back(w);
                pushed++;
                if (refWords.size() == PACK) begin
                    acc = '0;
                    for (int k = 0; k < PACK; k++) acc |= OUT_WIDTH'(refWords[k]) << (k * WIDTH);
                    expData.push_back(acc);
                    expCnt.push_back(PACK);
                    refWords.delete();
                end
            end

            if (pushed == nWords && refWords.size() > 0 && !flushed) begin
                idle = (empty && !out_valid) ? idle + 1 : 0;
                if (idle >= 4) begin
                    flush = 1'b1;
                    acc = '0;
                    for (int k = 0; k < refWords.size(); k++) acc |= OUT_WIDTH'(refWords[k]) << (k * WIDTH);
                    expData.push_back(acc);
                    expCnt.push_back(refWords.size());
                    refWords.delete();
                    flushed = 1'b1;
                end
            end
            @(negedge rd_clk);
            cycles++;
        end
        flush     = 1'b0;
        out_ready = 1'b0;
        if (got < expectedOuts) begin
            total++;
            bad++;
            $display("[TB] FAIL rand_timeout: words got %0d expected %0d", got, expectedOuts);
        end
    endtask

    initial begin
        int rdCount, firstRd, lastRd, validCount;
        logic [OUT_WIDTH-1:0] seenData;
        logic [CNT_WIDTH-1:0] seenCount;

        res       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;

        vecs[0].words = {8'h44, 8'h33, 8'h22, 8'h11}; vecs[0].nWords = 4; vecs[0].doFlush = 1'b0;
        vecs[0].expData = 32'h44332211; vecs[0].expCount = 4;
        vecs[1].words = {8'h00, 8'h00, 8'hBB, 8'hAA}; vecs[1].nWords = 2; vecs[1].doFlush = 1'b1;
        vecs[1].expData = 32'h0000BBAA; vecs[1].expCount = 2;
        vecs[2].words = {8'h00, 8'h00, 8'h00, 8'hCC}; vecs[2].nWords = 1; vecs[2].doFlush = 1'b1;
        vecs[2].expData = 32'h000000CC; vecs[2].expCount = 1;
        vecs[3].words = {8'h00, 8'h03, 8'h02, 8'h01}; vecs[3].nWords = 3; vecs[3].doFlush = 1'b1;
        vecs[3].expData = 32'h00030201; vecs[3].expCount = 3;
        vecs[4].words = {8'hEF, 8'hBE, 8'hAD, 8'hDE}; vecs[4].nWords = 4; vecs[4].doFlush = 1'b0;
        vecs[4].expData = 32'hEFBEADDE; vecs[4].expCount = 4;

        @(negedge rd_clk);
        @(negedge rd_clk);

        // Reset state, with a word already waiting so rd_en must be held off by res.
        pushWord(8'h5A);
        #1;
        checkOutput("reset_rd_en_forced", OUT_WIDTH'(rd_en), '0);
        checkOutput("reset_valid", OUT_WIDTH'(out_valid), '0);
        checkOutput("reset_data", out_data, '0);
        checkOutput("reset_count", OUT_WIDTH'(out_count), '0);
        @(negedge rd_clk);
        doReset();
        repeat (4) @(negedge rd_clk);
        pulseFlush();
        waitValid("stray_flush", 10);
        acceptWord("stray_flush");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Preloaded word with ready high: four back-to-back pops and a single valid beat.
        res = 1'b1;
        pushWord(8'h11); pushWord(8'h22); pushWord(8'h33); pushWord(8'h44);
        @(negedge rd_clk);
        res = 1'b0;
        out_ready = 1'b1;
        rdCount = 0; firstRd = -1; lastRd = -1; validCount = 0;
        seenData = '0; seenCount = '0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (rd_en) begin
                rdCount++;
                if (firstRd < 0) firstRd = i;
                lastRd = i;
            end
            if (out_valid) begin
                validCount++;
                seenData  = out_data;
                seenCount = out_count;
            end
            @(negedge rd_clk);
        end
        out_ready = 1'b0;
        checkOutput("burst_rd_en_cycles", OUT_WIDTH'(rdCount), OUT_WIDTH'(4));
        checkOutput("burst_rd_en_span", OUT_WIDTH'(lastRd - firstRd + 1), OUT_WIDTH'(4));
        checkOutput("burst_valid_cycles", OUT_WIDTH'(validCount), OUT_WIDTH'(1));
        checkOutput("burst_data", seenData, 32'h44332211);
        checkOutput("burst_count", OUT_WIDTH'(seenCount), OUT_WIDTH'(4));

        // Backpressure: word held stable with no pops while the FIFO still has data.
        doReset();
        for (int k = 1; k <= 8; k++) pushWord(WIDTH'(k));
        waitValid("hold1", 20);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("hold_no_pop", OUT_WIDTH'(rd_en), '0);
            checkOutput("hold_data", out_data, 32'h04030201);
            @(negedge rd_clk);
        end
        acceptWord("hold1");
        waitValid("hold2", 20);
        checkOutput("hold2_data", out_data, 32'h08070605);
        checkOutput("hold2_count", OUT_WIDTH'(out_count), OUT_WIDTH'(4));
        acceptWord("hold2");

        // Flush with nothing captured is ignored and must not block later pops.
        doReset();
        pulseFlush();
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput("idle_flush_quiet", OUT_WIDTH'({out_valid, rd_en}), '0);
            @(negedge rd_clk);
        end
        pushWord(8'h10); pushWord(8'h20); pushWord(8'h30); pushWord(8'h40);
        waitValid("idle_flush_after", 20);
        checkOutput("idle_flush_after_data", out_data, 32'h40302010);
        checkOutput("idle_flush_after_count", OUT_WIDTH'(out_count), OUT_WIDTH'(4));
        acceptWord("idle_flush_after");

        // Flush while a pop is still in flight: the in-flight word lands before the emit.
        doReset();
        pushWord(8'hCC);
        @(negedge rd_clk);
        pulseFlush();
        pushWord(8'hDD);
        waitValid("flush_pend", 20);
        checkOutput("flush_pend_data", out_data, 32'h000000CC);
        checkOutput("flush_pend_count", OUT_WIDTH'(out_count), OUT_WIDTH'(1));
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("flush_pend_no_pop", OUT_WIDTH'(rd_en), '0);
            @(negedge rd_clk);
        end
        acceptWord("flush_pend");
        repeat (6) @(negedge rd_clk);
        pulseFlush();
        waitValid("flush_next", 20);
        checkOutput("flush_next_data", out_data, 32'h000000DD);
        checkOutput("flush_next_count", OUT_WIDTH'(out_count), OUT_WIDTH'(1));
        acceptWord("flush_next");

        // Reset with three lanes filled and a fourth pop in flight discards all of it.
        doReset();
        pushWord(8'hA1); pushWord(8'hA2); pushWord(8'hA3);
        repeat (6) @(negedge rd_clk);
        pushWord(8'hA4); pushWord(8'hA5);
        @(negedge rd_clk);
        res = 1'b1;
        @(negedge rd_clk);
        #1;
        checkOutput("midrst_valid", OUT_WIDTH'(out_valid), '0);
        checkOutput("midrst_data", out_data, '0);
        checkOutput("midrst_rd_en", OUT_WIDTH'(rd_en), '0);
        @(negedge rd_clk);
        res = 1'b0;
        pushWord(8'hB1); pushWord(8'hB2); pushWord(8'hB3);
        waitValid("midrst_next", 20);
        checkOutput("midrst_next_data", out_data, 32'hB3B2B1A5);
        checkOutput("midrst_next_count", OUT_WIDTH'(out_count), OUT_WIDTH'(4));
        acceptWord("midrst_next");

        runRandom(42);

        checkOutput("no_underflow", OUT_WIDTH'(underflowCnt), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the async FIFO, clocked in the read domain.
- Pops WIDTH-bit words through the FIFO's rd_en/rdata/empty port and packs PACK consecutive words into one OUT_WIDTH word.
- Presents the packed word on a valid/ready interface to the downstream datapath.
- A flush request emits a partial word with its valid-lane count, so trailing data is not stranded.

Parameters:
- WIDTH, 8, FIFO data width (matches async FIFO WIDTH).
- PACK, 4, FIFO words per output word (2..16).
- OUT_WIDTH, WIDTH*PACK, output data width (derived, do not override).
- CNT_WIDTH, $clog2(PACK+1), width of lane counters and out_count (derived).

Ports:
- rd_clk  in  1  read-domain clock, same clock as the FIFO read side.
- res  in  1  synchronous active-high reset.
- empty  in  1  FIFO empty flag.
- rdata  in  WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- rd_en  out  1  FIFO pop request.
- flush  in  1  single-cycle pulse: emit the partial word.
- out_ready  in  1  downstream accepts out_data.
- out_valid  out  1  out_data/out_count valid.
- out_data  out  OUT_WIDTH  packed word; lane 0 = bits [WIDTH-1:0] = oldest word.
- out_count  out  CNT_WIDTH  number of valid lanes, 1..PACK.

Behaviour:
- Reset (res=1 at posedge rd_clk):
  - state=FILL; issued=0; filled=0; rd_pending=0; flush_req=0.
  - out_valid=0; out_data=0; out_count=0.
  - rd_en is forced 0 combinationally while res=1.
  - Reset mid-operation discards any pending pop and any partial lanes; those words are lost by design.
- States: FILL, HOLD.
- rd_en (combinational) = !res && state==FILL && !empty && issued<PACK && !flush_req.
  - Never pops while empty, so the FIFO underflow flag must stay 0.
- Each cycle rd_en=1: issued+1, rd_pending<=1. Otherwise rd_pending<=0.
- Capture:
  - When rd_pending=1, rdata is written into lane[filled] and filled+1.
  - Back-to-back pops sustain 1 word/cycle.
  - Latency: first rd_en to capture is 1 cycle; the last capture of a full word sets out_valid on the next edge.
- FILL->HOLD (full word): the cycle the capture makes filled==PACK.
  - Next cycle out_valid=1, out_count=PACK, out_data = all lanes.
- Flush:
  - flush pulse in FILL with filled>0 or a pop pending: set flush_req, which blocks new pops.
  - Once rd_pending=0 and flush_req=1: go to HOLD with out_count=filled. Unused upper lanes are driven 0.
  - flush with filled==0 and no pending pop: ignored, flush_req stays 0.
  - flush in HOLD: ignored.
  - flush in the same cycle as the capture that fills the last lane: full word emitted, flush_req cleared.
- HOLD:
  - out_valid=1; out_data/out_count stable until handshake; no pops.
  - On out_valid && out_ready: next cycle out_valid=0, out_data=0, out_count=0, filled=0, issued=0, flush_req=0, state=FILL.
  - Popping resumes the cycle after the handshake (one bubble per output word, accepted).
- out_ready is ignored while out_valid=0.
- Widths: issued, filled and out_count are CNT_WIDTH, so PACK itself is representable. Lane index filled is < PACK whenever a capture occurs.

Decomposition:
- Shared package (async-FIFO package) holds:
  - typedef for state enum {FILL, HOLD};
  - default WIDTH constant shared with async_fifo;
  - a function returning CNT_WIDTH for a given PACK.
- No sub-module: the lane register array and control fit in one module, roughly 150–200 lines.

Test Plan:
- FIFO preloaded with 0x11,0x22,0x33,0x44, out_ready=1 -> rd_en high 4 consecutive cycles; out_valid 1 cycle with out_data=0x44332211, out_count=4; FIFO underflow stays 0.
- 8 words 0x01..0x08 preloaded, out_ready held 0 for 10 cycles then 1 -> first word 0x04030201 held stable (no rd_en during HOLD); after handshake, second word 0x08070605.
- Push 0xAA,0xBB, wait for capture, pulse flush -> out_data=0x0000BBAA, out_count=2; lanes 2–3 zero.
- flush pulsed with FIFO empty and filled=0 -> no out_valid, no rd_en, state stays FILL.
- Pulse flush the cycle after a pop of 0xCC (rd_pending=1) -> 0xCC captured first; output 0x000000CC with count 1; no further pop until handshake.
- Assert res for 1 cycle while filled=3 and a pop is pending -> next cycle out_valid=0, out_data=0, rd_en=0; subsequent 4 words pack correctly from lane 0.
